// File: rtl/dmem_pkg.sv
// Shared constants, FSM encoding and access-width helpers for the data-memory arbiter.
package dmem_pkg;

  localparam int unsigned DefAddrWidth = 9;

  // RISC-V load/store width codes
  localparam logic [2:0] Func3B  = 3'b000;
  localparam logic [2:0] Func3H  = 3'b001;
  localparam logic [2:0] Func3W  = 3'b010;
  localparam logic [2:0] Func3Bu = 3'b100;
  localparam logic [2:0] Func3Hu = 3'b101;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  // Undefined width codes behave as a full word.
  function automatic logic [2:0] norm_func3(input logic [2:0] func3);
    case (func3)
      Func3B, Func3H, Func3W, Func3Bu, Func3Hu: norm_func3 = func3;
      default:                                  norm_func3 = Func3W;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [2:0] func3, input logic [1:0] addr_lsb);
    case (norm_func3(func3))
      Func3B, Func3Bu: is_aligned = 1'b1;
      Func3H, Func3Hu: is_aligned = ~addr_lsb[0];
      default:         is_aligned = (addr_lsb == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/response bundle for both requesters plus the RAM-side signals.
interface dmem_arbiter_if
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth
) ();

  logic                  req0, req1;
  logic                  we0, we1;
  logic [ADDR_WIDTH-1:0] addr0, addr1;
  logic [31:0]           wdata0, wdata1;
  logic [2:0]            func3_0, func3_1;
  logic                  gnt0, gnt1;
  logic                  rvalid0, rvalid1;
  logic [31:0]           rdata0, rdata1;
  logic                  err0, err1;
  logic                  stall0;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_data;
  logic [2:0]            mem_func3;
  logic [31:0]           mem_q;

  // Arbiter side
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, func3_0, func3_1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1, stall0,
    output mem_we, mem_addr, mem_data, mem_func3,
    input  mem_q
  );

  // Requester / RAM side
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, func3_0, func3_1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1, stall0,
    input  mem_we, mem_addr, mem_data, mem_func3,
    output mem_q
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin selector with a last-served pointer.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic       valid_o,
  output logic       win_o
);

  logic last_q, last_d;

  // Lone requester wins; on a tie the port not served last wins.
  always_comb begin
    valid_o = |req_i;
    if (&req_i) begin
      win_o = ~last_q;
    end else begin
      win_o = req_i[1];
    end
    last_d = accept_i ? win_o : last_q;
  end

  // Pointer resets to port 1 so port 0 takes the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data RAM: IDLE -> ACCESS -> RESP.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth
) (
  input logic          clk,
  input logic          rst_n,
  dmem_arbiter_if.slave bus
);

  state_e                state_q, state_d;
  logic                  win_q, win_d;
  logic                  hold_we_q, hold_we_d;
  logic [ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
  logic [31:0]           hold_wdata_q, hold_wdata_d;
  logic [2:0]            hold_func3_q, hold_func3_d;
  logic [1:0]            gnt_q, gnt_d;
  logic [1:0]            rvalid_q, rvalid_d;
  logic [1:0]            err_q, err_d;
  logic [31:0]           rdata0_q, rdata0_d;
  logic [31:0]           rdata1_q, rdata1_d;

  logic        arb_valid, arb_win, accept;
  logic        hold_aligned;
  logic [31:0] resp_data;

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    ({bus.req1, bus.req0}),
    .accept_i (accept),
    .valid_o  (arb_valid),
    .win_o    (arb_win)
  );

  assign hold_aligned = is_aligned(hold_func3_q, hold_addr_q[1:0]);
  // Stores and misaligned accesses return zero.
  assign resp_data    = (hold_we_q || !hold_aligned) ? 32'h0 : bus.mem_q;

  // Next-state: accept in IDLE/RESP, complete at the end of ACCESS.
  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    hold_we_d    = hold_we_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    hold_func3_d = hold_func3_q;
    gnt_d        = 2'b00;
    rvalid_d     = 2'b00;
    err_d        = 2'b00;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    accept       = 1'b0;
    case (state_q)
      StIdle, StResp: begin
        if (arb_valid) begin
          accept       = 1'b1;
          win_d        = arb_win;
          hold_we_d    = arb_win ? bus.we1 : bus.we0;
          hold_addr_d  = arb_win ? bus.addr1 : bus.addr0;
          hold_wdata_d = arb_win ? bus.wdata1 : bus.wdata0;
          hold_func3_d = norm_func3(arb_win ? bus.func3_1 : bus.func3_0);
          gnt_d[arb_win] = 1'b1;
          state_d      = StAccess;
        end else begin
          state_d = StIdle;
        end
      end
      StAccess: begin
        rvalid_d[win_q] = 1'b1;
        err_d[win_q]    = ~hold_aligned;
        if (win_q) begin
          rdata1_d = resp_data;
        end else begin
          rdata0_d = resp_data;
        end
        state_d = StResp;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM and registered outputs; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      win_q        <= 1'b0;
      hold_we_q    <= 1'b0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      hold_func3_q <= '0;
      gnt_q        <= 2'b00;
      rvalid_q     <= 2'b00;
      err_q        <= 2'b00;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      hold_we_q    <= hold_we_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      hold_func3_q <= hold_func3_d;
      gnt_q        <= gnt_d;
      rvalid_q     <= rvalid_d;
      err_q        <= err_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  // Write enable decoded from state so an async reset drops it at once.
  always_comb begin
    bus.mem_we    = (state_q == StAccess) && hold_we_q && hold_aligned;
    bus.mem_addr  = hold_addr_q;
    bus.mem_data  = hold_wdata_q;
    bus.mem_func3 = hold_func3_q;
    bus.gnt0      = gnt_q[0];
    bus.gnt1      = gnt_q[1];
    bus.rvalid0   = rvalid_q[0];
    bus.rvalid1   = rvalid_q[1];
    bus.err0      = err_q[0];
    bus.err1      = err_q[1];
    bus.rdata0    = rdata0_q;
    bus.rdata1    = rdata1_q;
    bus.stall0    = bus.req0 & ~gnt_q[0] & ~rvalid_q[0];
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, meaning the byte-address width of the shared data RAM.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, the reset; asynchronous and active-low.
REQ-004 SHALL have ports req0/req1, input, 1 each, meaning transaction request (port 0 = CPU MEM stage, port 1 = loader/debug).
REQ-005 SHALL have ports we0/we1, input, 1 each, meaning store (1) or load (0).
REQ-006 SHALL have ports addr0/addr1, input, ADDR_WIDTH each, meaning byte address.
REQ-007 SHALL have ports wdata0/wdata1, input, 32 each, meaning store data.
REQ-008 SHALL have ports func3_0/func3_1, input, 3 each, meaning the RISC-V width code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-009 SHALL have ports gnt0/gnt1, output, 1 each, meaning a one-cycle accept pulse.
REQ-010 SHALL have ports rvalid0/rvalid1, output, 1 each, meaning a one-cycle completion pulse.
REQ-011 SHALL have ports rdata0/rdata1, output, 32 each, meaning load result, valid with rvalid.
REQ-012 SHALL have ports err0/err1, output, 1 each, meaning misaligned access, valid with rvalid.
REQ-013 SHALL have port stall0, output, 1, meaning req0 & ~gnt0 & ~rvalid0, the CPU pipeline freeze.
REQ-014 SHALL have RAM-side ports mem_we, mem_addr, mem_data and mem_func3 (outputs), plus mem_q (input, 32), where mem_q is the combinational read data.

Function
REQ-015 SHALL implement states IDLE, ACCESS and RESP.
REQ-016 IDLE: if any reqX=1 at the clock edge, SHALL latch the winner's we/addr/wdata/func3 into hold registers and go to ACCESS; otherwise SHALL stay in IDLE.
REQ-017 Arbitration SHALL be 2-way round-robin: a lone requester wins; if both request, the port not served last wins; the last-served pointer updates only on an accept.
REQ-018 ACCESS (exactly 1 cycle): gntX SHALL be 1 for the winner only, and mem_* SHALL be driven from the hold registers.
REQ-019 In ACCESS, mem_we SHALL equal the held we AND aligned; req inputs SHALL be ignored.
REQ-020 At the end of ACCESS, mem_q SHALL be registered into the winner's rdata; the FSM SHALL go to RESP.
REQ-021 RESP: rvalidX SHALL be 1 for one cycle for both loads and stores; a store's rdata SHALL be 0.
REQ-022 RESP SHALL arbitrate exactly like IDLE, giving a throughput of 1 transaction per 2 cycles.
REQ-023 Alignment rule: W requires addr[1:0]==0; H/HU requires addr[0]==0; B/BU is always aligned.
REQ-024 A misaligned access SHALL have mem_we forced to 0, and SHALL complete with errX=1 and rdataX=0.
REQ-025 Undefined func3 codes SHALL be treated as W.
REQ-026 Outside ACCESS, mem_we SHALL be 0; mem_addr/mem_data/mem_func3 SHALL hold their last values.
REQ-027 A requester SHALL keep its request stable until gnt; it may drop or change req in the cycle after gnt.
REQ-028 rdataX SHALL hold its value until the next rvalidX.

Reset
REQ-029 rst_n=0 SHALL immediately force: state IDLE; gnt*, rvalid*, err* and mem_we = 0; rdata*, hold registers and mem_addr/mem_data/mem_func3 = 0.
REQ-030 Reset SHALL set the last-served pointer to port 1, so port 0 wins the first tie.
REQ-031 Reset asserted during ACCESS SHALL abort the write, with mem_we falling asynchronously; no rvalid SHALL follow.

Structure
REQ-032 A shared package dmem_pkg SHALL hold the func3 width constants, the ADDR_WIDTH default and the FSM state encoding.
REQ-033 The round-robin selection and pointer SHALL be one sub-module, rr_arb2.
REQ-034 The alignment check SHALL be a function in dmem_pkg.

Verification
REQ-035 Port-0 SW, addr=0x010, data=0xFFFFABCD, then LW of 0x010 -> gnt0 in the ACCESS cycle; rvalid0 one cycle later; load rdata0=0xFFFFABCD, err0=0.
REQ-036 After REQ-035, LB/LH/LBU/LHU of 0x010 -> rdata0 = 0xFFFFFFCD, 0xFFFFABCD, 0x000000CD, 0x0000ABCD.
REQ-037 req0 and req1 held high for 8 cycles -> grant order 0,1,0,1 at a 2-cycle period; stall0=1 while port 1 is served.
REQ-038 Port-1 SW to 0x013 and LH from 0x011 -> err1=1, rdata1=0; mem_we never 1; the word at 0x010 is unchanged.
REQ-039 rst_n pulled low mid-ACCESS of a port-0 SW to 0x020 -> mem_we drops immediately; no rvalid0; the FSM is IDLE and port 0 wins the next tie.
